// File: rtl/sensor_event_hub.sv
// Conditions NUM_CH sensor levels (sync, debounce, rise-detect) and arbitrates pending events onto one port.
// Latency: ch_in change to evt_valid is DEB_CYCLES+4 cycles.
// Backpressure: evt_id/evt_valid hold while evt_ready=0; repeat edges merge into pending and raise ovf.
module sensor_event_hub #(
    parameter int NUM_CH     = 8,
    parameter int DEB_CYCLES = 100000,
    parameter int ARB_MODE   = 0,
    parameter int CH_W       = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_in,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic              clr_ovf,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_id,
    output logic [NUM_CH-1:0] ch_level,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] ovf
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic [NUM_CH-1:0] sync1, sync2, level_d;
    logic [NUM_CH-1:0] rise, gnt_onehot, ovf_set;
    logic [CH_W-1:0]   rr_ptr, gnt_idx;
    logic              gnt_found, can_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level_d <= '0;
        end else begin
            sync1   <= ch_in;
            sync2   <= sync1;
            level_d <= ch_level;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
        logic [CNT_W-1:0] cnt;
        logic             lvl;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                cnt <= '0;
                lvl <= ~lvl;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign ch_level[g] = lvl;
    end

    assign rise = ch_level & ~level_d & ch_mask;

    // Round-robin search starts at rr_ptr and wraps; fixed mode always starts at 0.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (ARB_MODE == 1) ? int'(rr_ptr) + k : k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_W'(idx);
            if (!gnt_found && pending[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign can_grant  = (!evt_valid || evt_ready) && gnt_found;
    assign gnt_onehot = can_grant ? ({{(NUM_CH-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign ovf_set    = rise & pending & ~gnt_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            ovf       <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            pending <= (pending & ~gnt_onehot) | rise;
            ovf     <= (clr_ovf ? '0 : ovf) | ovf_set;
            if (can_grant) begin
                evt_valid <= 1'b1;
                evt_id    <= gnt_idx;
                rr_ptr    <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sensor_event_hub.sv
// Directed bench: fixed-priority and round-robin hubs share stimulus, NUM_CH=8, DEB_CYCLES=4.
module tb_sensor_event_hub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ch_in, ch_mask;
    logic       clr_ovf, evt_ready;

    logic       fx_evt_valid, rr_evt_valid;
    logic [2:0] fx_evt_id, rr_evt_id;
    logic [7:0] fx_ch_level, fx_pending, fx_ovf;
    logic [7:0] rr_ch_level, rr_pending, rr_ovf;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sensor_event_hub #(.NUM_CH(8), .DEB_CYCLES(4), .ARB_MODE(0)) dut_fx (
        .clk(clk), .rst_n(rst_n), .ch_in(ch_in), .ch_mask(ch_mask), .clr_ovf(clr_ovf),
        .evt_valid(fx_evt_valid), .evt_ready(evt_ready), .evt_id(fx_evt_id),
        .ch_level(fx_ch_level), .pending(fx_pending), .ovf(fx_ovf));

    sensor_event_hub #(.NUM_CH(8), .DEB_CYCLES(4), .ARB_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .ch_in(ch_in), .ch_mask(ch_mask), .clr_ovf(clr_ovf),
        .evt_valid(rr_evt_valid), .evt_ready(evt_ready), .evt_id(rr_evt_id),
        .ch_level(rr_ch_level), .pending(rr_pending), .ovf(rr_ovf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ch_in = '0; ch_mask = '1; clr_ovf = 1'b0; evt_ready = 1'b0;
        repeat (3) tick();
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", fx_evt_valid); else passed++;
        checks++; if (fx_evt_id !== 3'd0) $display("FAIL reset_id got %0d want 0", fx_evt_id); else passed++;
        checks++; if (fx_ch_level !== 8'h00) $display("FAIL reset_level got %h want 00", fx_ch_level); else passed++;
        checks++; if (fx_pending !== 8'h00) $display("FAIL reset_pending got %h want 00", fx_pending); else passed++;
        checks++; if (fx_ovf !== 8'h00) $display("FAIL reset_ovf got %h want 00", fx_ovf); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_debounce();
        evt_ready = 1'b1;
        ch_in[2] = 1'b1;
        repeat (3) tick();
        ch_in[2] = 1'b0;
        repeat (10) tick();
        checks++; if (fx_ch_level !== 8'h00) $display("FAIL glitch_level got %h want 00", fx_ch_level); else passed++;
        checks++; if (fx_pending !== 8'h00) $display("FAIL glitch_pending got %h want 00", fx_pending); else passed++;
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL glitch_valid got %b want 0", fx_evt_valid); else passed++;
        ch_in[2] = 1'b1;
        repeat (5) tick();
        checks++; if (fx_ch_level[2] !== 1'b0) $display("FAIL deb_level_c5 got %b want 0", fx_ch_level[2]); else passed++;
        tick();
        checks++; if (fx_ch_level[2] !== 1'b1) $display("FAIL deb_level_c6 got %b want 1", fx_ch_level[2]); else passed++;
        tick();
        checks++; if (fx_pending !== 8'h04) $display("FAIL deb_pending_c7 got %h want 04", fx_pending); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b1) $display("FAIL deb_valid_c8 got %b want 1", fx_evt_valid); else passed++;
        checks++; if (fx_evt_id !== 3'd2) $display("FAIL deb_id_c8 got %0d want 2", fx_evt_id); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL deb_valid_c9 got %b want 0", fx_evt_valid); else passed++;
        ch_in = '0;
        repeat (8) tick();
        checks++; if (fx_ch_level !== 8'h00) $display("FAIL fall_level got %h want 00", fx_ch_level); else passed++;
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL fall_no_event got %b want 0", fx_evt_valid); else passed++;
    endtask

    task automatic test_fixed_prio();
        evt_ready = 1'b1;
        ch_in = 8'h62;
        repeat (7) tick();
        checks++; if (fx_pending !== 8'h62) $display("FAIL prio_pending got %h want 62", fx_pending); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd1) $display("FAIL prio_first got v=%b id=%0d want v=1 id=1", fx_evt_valid, fx_evt_id); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd5) $display("FAIL prio_second got v=%b id=%0d want v=1 id=5", fx_evt_valid, fx_evt_id); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd6) $display("FAIL prio_third got v=%b id=%0d want v=1 id=6", fx_evt_valid, fx_evt_id); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL prio_drain got %b want 0", fx_evt_valid); else passed++;
        ch_in = '0;
        repeat (8) tick();
    endtask

    task automatic test_round_robin();
        evt_ready = 1'b1;
        ch_in[5] = 1'b1;
        repeat (8) tick();
        checks++; if (rr_evt_valid !== 1'b1 || rr_evt_id !== 3'd5) $display("FAIL rr_ch5 got v=%b id=%0d want v=1 id=5", rr_evt_valid, rr_evt_id); else passed++;
        ch_in = '0;
        repeat (8) tick();
        ch_in = 8'h42;
        repeat (8) tick();
        checks++; if (rr_evt_valid !== 1'b1 || rr_evt_id !== 3'd6) $display("FAIL rr_first got v=%b id=%0d want v=1 id=6", rr_evt_valid, rr_evt_id); else passed++;
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd1) $display("FAIL fx_first got v=%b id=%0d want v=1 id=1", fx_evt_valid, fx_evt_id); else passed++;
        tick();
        checks++; if (rr_evt_valid !== 1'b1 || rr_evt_id !== 3'd1) $display("FAIL rr_second got v=%b id=%0d want v=1 id=1", rr_evt_valid, rr_evt_id); else passed++;
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd6) $display("FAIL fx_second got v=%b id=%0d want v=1 id=6", fx_evt_valid, fx_evt_id); else passed++;
        tick();
        checks++; if (rr_evt_valid !== 1'b0) $display("FAIL rr_drain got %b want 0", rr_evt_valid); else passed++;
        ch_in = '0;
        repeat (8) tick();
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        ch_in[3] = 1'b1;
        repeat (8) tick();
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd3) $display("FAIL bp_first got v=%b id=%0d want v=1 id=3", fx_evt_valid, fx_evt_id); else passed++;
        ch_in = '0;
        repeat (8) tick();
        ch_in[3] = 1'b1;
        repeat (8) tick();
        checks++; if (fx_pending !== 8'h08) $display("FAIL bp_pending2 got %h want 08", fx_pending); else passed++;
        checks++; if (fx_ovf !== 8'h00) $display("FAIL bp_ovf2 got %h want 00", fx_ovf); else passed++;
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd3) $display("FAIL bp_hold2 got v=%b id=%0d want v=1 id=3", fx_evt_valid, fx_evt_id); else passed++;
        ch_in = '0;
        repeat (8) tick();
        ch_in[3] = 1'b1;
        repeat (8) tick();
        checks++; if (fx_ovf !== 8'h08) $display("FAIL bp_ovf3 got %h want 08", fx_ovf); else passed++;
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd3) $display("FAIL bp_hold3 got v=%b id=%0d want v=1 id=3", fx_evt_valid, fx_evt_id); else passed++;
        evt_ready = 1'b1;
        tick();
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd3) $display("FAIL bp_again got v=%b id=%0d want v=1 id=3", fx_evt_valid, fx_evt_id); else passed++;
        checks++; if (fx_pending !== 8'h00) $display("FAIL bp_pending_clr got %h want 00", fx_pending); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", fx_evt_valid); else passed++;
        checks++; if (fx_ovf !== 8'h08) $display("FAIL bp_ovf_sticky got %h want 08", fx_ovf); else passed++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++; if (fx_ovf !== 8'h00) $display("FAIL bp_ovf_clr got %h want 00", fx_ovf); else passed++;
        ch_in = '0;
        repeat (8) tick();
    endtask

    task automatic test_mask_same_cycle();
        evt_ready = 1'b1;
        ch_mask = 8'hEF;
        ch_in[4] = 1'b1;
        repeat (10) tick();
        checks++; if (fx_ch_level[4] !== 1'b1) $display("FAIL mask_level got %b want 1", fx_ch_level[4]); else passed++;
        checks++; if (fx_pending !== 8'h00) $display("FAIL mask_pending got %h want 00", fx_pending); else passed++;
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL mask_valid got %b want 0", fx_evt_valid); else passed++;
        ch_in = '0;
        repeat (8) tick();
        ch_mask = '1;
        evt_ready = 1'b0;
        ch_in[0] = 1'b1;
        repeat (8) tick();
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd0) $display("FAIL same_first got v=%b id=%0d want v=1 id=0", fx_evt_valid, fx_evt_id); else passed++;
        ch_in = '0;
        repeat (8) tick();
        ch_in[0] = 1'b1;
        repeat (8) tick();
        checks++; if (fx_pending !== 8'h01) $display("FAIL same_pending2 got %h want 01", fx_pending); else passed++;
        ch_in = '0;
        repeat (8) tick();
        ch_in[0] = 1'b1;
        repeat (6) tick();
        evt_ready = 1'b1;
        tick();
        checks++; if (fx_pending !== 8'h01) $display("FAIL same_pending_kept got %h want 01", fx_pending); else passed++;
        checks++; if (fx_ovf !== 8'h00) $display("FAIL same_no_ovf got %h want 00", fx_ovf); else passed++;
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd0) $display("FAIL same_granted got v=%b id=%0d want v=1 id=0", fx_evt_valid, fx_evt_id); else passed++;
        tick();
        checks++; if (fx_pending !== 8'h00 || fx_evt_valid !== 1'b1) $display("FAIL same_regrant got p=%h v=%b want p=00 v=1", fx_pending, fx_evt_valid); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL same_drain got %b want 0", fx_evt_valid); else passed++;
        ch_in = '0;
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        ch_in[7] = 1'b1;
        repeat (8) tick();
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd7) $display("FAIL rst_pre got v=%b id=%0d want v=1 id=7", fx_evt_valid, fx_evt_id); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", fx_evt_valid); else passed++;
        checks++; if (fx_pending !== 8'h00) $display("FAIL rst_pending got %h want 00", fx_pending); else passed++;
        checks++; if (fx_ovf !== 8'h00) $display("FAIL rst_ovf got %h want 00", fx_ovf); else passed++;
        checks++; if (fx_ch_level !== 8'h00) $display("FAIL rst_level got %h want 00", fx_ch_level); else passed++;
        checks++; if (rr_evt_valid !== 1'b0) $display("FAIL rst_rr_valid got %b want 0", rr_evt_valid); else passed++;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (7) tick();
        checks++; if (fx_evt_valid !== 1'b0) $display("FAIL rst_early got %b want 0", fx_evt_valid); else passed++;
        tick();
        checks++; if (fx_evt_valid !== 1'b1 || fx_evt_id !== 3'd7) $display("FAIL rst_reevent got v=%b id=%0d want v=1 id=7", fx_evt_valid, fx_evt_id); else passed++;
        ch_in = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_fixed_prio();
        test_round_robin();
        test_backpressure();
        test_mask_same_cycle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
